playback_sequencer: RTL

PLAYBACK_SEQUENCER -- requirements
Module: playback_sequencer

---
 rtl/playback_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/playback_sequencer.sv
// Replays a window of capture memory at a programmable rate with run/pause/step/loop
// control; read data appears on sample two cycles after each memory read strobe.
module playback_sequencer #(
    parameter int SAMPLE_DEPTH      = 4096,
    parameter int TOTAL_PROBE_WIDTH = 7,
    parameter int DIV_WIDTH         = 16,
    localparam int ADDR_W           = $clog2(SAMPLE_DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         step,
    input  logic                         loop_en,
    input  logic [DIV_WIDTH-1:0]         rate_div,
    input  logic [ADDR_W-1:0]            start_addr,
    input  logic [ADDR_W-1:0]            end_addr,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic                         mem_rd_en,
    input  logic [TOTAL_PROBE_WIDTH-1:0] mem_rdata,
    output logic [TOTAL_PROBE_WIDTH-1:0] sample,
    output logic                         sample_valid,
    output logic [1:0]                   state,
    output logic                         done,
    output logic [15:0]                  loop_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 cur_state;
    state_t                 nxt_state;
    logic [ADDR_W-1:0]      ptr;
    logic [ADDR_W-1:0]      start_lat;
    logic [ADDR_W-1:0]      end_lat;
    logic [DIV_WIDTH-1:0]   rate_lat;
    logic [DIV_WIDTH-1:0]   div_cnt;
    logic                   loop_lat;
    logic                   vld_p1;
    logic                   load;
    logic                   at_end;
    logic                   resume;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign load     = start && ((cur_state == S_IDLE) || (cur_state == S_DONE));
    assign resume   = (cur_state == S_PAUSE) && start && !stop;
    assign at_end   = (ptr == end_lat);
    assign mem_addr = ptr;
    assign state    = cur_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_IDLE, S_DONE: begin
                if (start) nxt_state = S_RUN;
            end
            S_RUN: begin
                // An end-of-window read without looping finishes even if stop arrives with it
                if (mem_rd_en && at_end && !loop_lat) nxt_state = S_DONE;
                else if (stop)                        nxt_state = S_PAUSE;
            end
            S_PAUSE: begin
                if (stop)                                  nxt_state = S_IDLE;
                else if (start)                            nxt_state = S_RUN;
                else if (mem_rd_en && at_end && !loop_lat) nxt_state = S_DONE;
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    always_comb begin
        mem_rd_en = 1'b0;
        done      = 1'b0;
        case (cur_state)
            S_RUN:   mem_rd_en = (div_cnt == '0);
            S_PAUSE: mem_rd_en = step && !start && !stop;
            S_DONE:  done      = 1'b1;
            default: ;
        endcase
    end

    // Stage p0: pointer, divider and pass counter advance on each issued read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= '0;
            start_lat  <= '0;
            end_lat    <= '0;
            rate_lat   <= '0;
            loop_lat   <= 1'b0;
            div_cnt    <= '0;
            loop_count <= '0;
        end else if (load) begin
            ptr        <= start_addr;
            start_lat  <= start_addr;
            end_lat    <= end_addr;
            rate_lat   <= rate_div;
            loop_lat   <= loop_en;
            div_cnt    <= '0;
            loop_count <= '0;
        end else begin
            if (mem_rd_en) begin
                ptr <= (at_end && loop_lat) ? start_lat : ptr + ADDR_W'(1);
                if (at_end) loop_count <= sat_inc(loop_count);
            end
            if (cur_state == S_RUN) begin
                if (mem_rd_en)  div_cnt <= rate_lat;
                else if (!stop) div_cnt <= div_cnt - DIV_WIDTH'(1);
            end else if (resume) begin
                div_cnt <= '0;
            end
        end
    end

    // Stage p1 -> p2: memory data arrives one cycle after the strobe and is registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1       <= 1'b0;
            sample_valid <= 1'b0;
            sample       <= '0;
        end else begin
            vld_p1       <= mem_rd_en;
            sample_valid <= vld_p1;
            if (vld_p1) sample <= mem_rdata;
        end
    end

endmodule
